min_control_sequencer: RTL and testbench



---
 rtl/min_control_sequencer.sv | 129 ++++++++++++
 tb/tb_min_control_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/min_control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the MIN processor; drives the EU control word.
// Optional conditional jump decode enabled by defining MIN_SEQ_BRANCH_EN.
module min_control_sequencer #(
   parameter bit HALT_ON_ILLEGAL = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] ifd,
   input  logic [3:0]  cc,
   output logic [17:0] eucntl,
   output logic [2:0]  opcntl,
   output logic        halted,
   output logic        instr_done
);

   typedef enum logic [4:0] {
      IDLE, FETCH, DECODE, LDI1, LDI2, X1, X2, X3, LD4, LD5, ST4,
      ALU1, ALU2, HALT, BR1, BR2, BN1, BN2
   } state_t;

   state_t      state, nxt;
   logic [15:0] ir;
   logic [3:0]  ccshadow;
   logic        unused_bits;

   wire [2:0] op   = ifd[15:13];
   wire [2:0] mode = ifd[12:10];
   wire [1:0] am   = ifd[5:4];

   // {asrc, adest, bsrc, bdest, alu, mem, ire_load}
   function automatic logic [17:0] fw(input logic [2:0] asrc, input logic [1:0] adest,
                                      input logic [2:0] bsrc, input logic [2:0] bdest,
                                      input logic [2:0] alu,  input logic [2:0] mem,
                                      input logic ire);
      return {asrc, adest, bsrc, bdest, alu, mem, ire};
   endfunction

   function automatic logic [17:0] word(input state_t s);
      logic [17:0] w;
      w = '0;
      case (s)
         FETCH:  w = fw(3'b011, 2'b00, 3'b000, 3'b000, 3'b001, 3'b010, 1'b0);
         DECODE: w = fw(3'b101, 2'b11, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1);
         LDI1:   w = fw(3'b010, 2'b00, 3'b000, 3'b000, 3'b000, 3'b001, 1'b0);
         LDI2:   w = fw(3'b000, 2'b00, 3'b111, 3'b001, 3'b000, 3'b000, 1'b0);
         X1:     w = fw(3'b011, 2'b00, 3'b000, 3'b000, 3'b001, 3'b001, 1'b0);
         X2:     w = fw(3'b101, 2'b11, 3'b111, 3'b100, 3'b000, 3'b000, 1'b0);
         X3:     w = fw(3'b010, 2'b00, 3'b110, 3'b000, 3'b010, 3'b000, 1'b0);
         LD4:    w = fw(3'b101, 2'b00, 3'b000, 3'b000, 3'b000, 3'b001, 1'b0);
         LD5:    w = fw(3'b000, 2'b00, 3'b111, 3'b001, 3'b000, 3'b000, 1'b0);
         ST4:    w = fw(3'b001, 2'b00, 3'b101, 3'b000, 3'b000, 3'b111, 1'b0);
         ALU1:   w = fw(3'b001, 2'b00, 3'b010, 3'b000, 3'b110, 3'b000, 1'b0);
         ALU2:   w = fw(3'b000, 2'b00, 3'b101, 3'b001, 3'b000, 3'b000, 1'b0);
         BR1:    w = fw(3'b011, 2'b00, 3'b000, 3'b000, 3'b000, 3'b001, 1'b0);
         BR2:    w = fw(3'b000, 2'b00, 3'b111, 3'b011, 3'b000, 3'b000, 1'b0);
         BN1:    w = fw(3'b011, 2'b00, 3'b000, 3'b000, 3'b001, 3'b000, 1'b0);
         BN2:    w = fw(3'b101, 2'b11, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
         default: w = '0;
      endcase
      return w;
   endfunction

   logic take;
   always_comb begin
      take = 1'b0;
      case (ifd[1:0])
         2'b00: take = 1'b1;
         2'b01: take = ccshadow[1];
         2'b10: take = ccshadow[2];
         default: take = 1'b0;
      endcase
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:   nxt = FETCH;
         FETCH:  nxt = DECODE;
         DECODE: begin
            if ({op, mode, am} == 8'b000_001_01)
               nxt = LDI1;
            else if ({op, mode, am} == 8'b000_001_10 || {op, mode, am} == 8'b000_010_10)
               nxt = X1;
            else if ((op == 3'b001 || op == 3'b010 || op == 3'b011) && mode == 3'b100)
               nxt = ALU1;
`ifdef MIN_SEQ_BRANCH_EN
            else if (op == 3'b000 && mode == 3'b011)
               nxt = take ? BR1 : BN1;
`endif
            else
               nxt = HALT_ON_ILLEGAL ? HALT : FETCH;
         end
         LDI1:   nxt = LDI2;
         X1:     nxt = X2;
         X2:     nxt = X3;
         // ld and st share X1..X3; the latched mode picks the tail
         X3:     nxt = (ir[12:10] == 3'b001) ? LD4 : ST4;
         LD4:    nxt = LD5;
         ALU1:   nxt = ALU2;
         BR1:    nxt = BR2;
         BN1:    nxt = BN2;
         HALT:   nxt = HALT;
         default: nxt = FETCH;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         eucntl     <= '0;
         opcntl     <= 3'b000;
         halted     <= 1'b0;
         instr_done <= 1'b0;
         ir         <= '0;
         ccshadow   <= '0;
      end else begin
         state      <= nxt;
         eucntl     <= word(nxt);
         halted     <= (nxt == HALT);
         instr_done <= (nxt inside {LDI2, LD5, ST4, ALU2, BR2, BN2});
         if (nxt == ALU1) opcntl <= op;
         if (state == DECODE) ir <= ifd;
         if (state == ALU1) ccshadow <= cc;
      end
   end

   assign unused_bits = ^{ir[15:13], ir[9:0], ccshadow, ifd[9:6], ifd[3:0], take};

endmodule

// File: tb/tb_min_control_sequencer.sv
// Scoreboard bench: stimulus queues the expected per-cycle outputs, a negedge monitor compares.
module tb_min_control_sequencer;
   logic        clock, reset;
   logic [15:0] ifd;
   logic [3:0]  cc;
   logic [17:0] eucntl;
   logic [2:0]  opcntl;
   logic        halted, instr_done;

   min_control_sequencer dut (
      .clock(clock), .reset(reset), .ifd(ifd), .cc(cc),
      .eucntl(eucntl), .opcntl(opcntl), .halted(halted), .instr_done(instr_done)
   );

   localparam logic [17:0] W_ZERO = 18'b000_00_000_000_000_000_0;
   localparam logic [17:0] W_F    = 18'b011_00_000_000_001_010_0;
   localparam logic [17:0] W_D    = 18'b101_11_000_000_000_000_1;
   localparam logic [17:0] W_LDI1 = 18'b010_00_000_000_000_001_0;
   localparam logic [17:0] W_LDI2 = 18'b000_00_111_001_000_000_0;
   localparam logic [17:0] W_X1   = 18'b011_00_000_000_001_001_0;
   localparam logic [17:0] W_X2   = 18'b101_11_111_100_000_000_0;
   localparam logic [17:0] W_X3   = 18'b010_00_110_000_010_000_0;
   localparam logic [17:0] W_LD4  = 18'b101_00_000_000_000_001_0;
   localparam logic [17:0] W_LD5  = 18'b000_00_111_001_000_000_0;
   localparam logic [17:0] W_ST4  = 18'b001_00_101_000_000_111_0;
   localparam logic [17:0] W_ALU1 = 18'b001_00_010_000_110_000_0;
   localparam logic [17:0] W_ALU2 = 18'b000_00_101_001_000_000_0;
   localparam logic [17:0] W_BR1  = 18'b011_00_000_000_000_001_0;
   localparam logic [17:0] W_BR2  = 18'b000_00_111_011_000_000_0;
   localparam logic [17:0] W_BN1  = 18'b011_00_000_000_001_000_0;
   localparam logic [17:0] W_BN2  = 18'b101_11_000_000_000_000_0;

   typedef struct {
      logic [17:0] w;
      logic [2:0]  op;
      logic        h;
      logic        d;
      string       tag;
   } exp_t;

   exp_t       q[$];
   logic [2:0] exp_op;
   int         checks, errors;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic push(input logic [17:0] w, input logic d, input logic h, input string tag);
      exp_t e;
      e.w = w; e.op = exp_op; e.h = h; e.d = d; e.tag = tag;
      q.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [17:0] act, input logic [17:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b want %b", nm, act, req);
      end
   endtask

   always @(negedge clock) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk({e.tag, ".eucntl"}, eucntl, e.w);
         chk({e.tag, ".opcntl"}, {15'd0, opcntl}, {15'd0, e.op});
         chk({e.tag, ".halted"}, {17'd0, halted}, {17'd0, e.h});
         chk({e.tag, ".done"}, {17'd0, instr_done}, {17'd0, e.d});
      end
   end

   // Entered in FETCH, #1 after the edge. ifd is only valid during DECODE; cc only during ALU1.
   task automatic run_instr(input logic [15:0] ins, input logic [3:0] c, input int n);
      ifd = 16'hFFFF; cc = ~c;
      @(posedge clock); #1;
      ifd = ins;
      @(posedge clock); #1;
      ifd = 16'hFFFF; cc = c;
      @(posedge clock); #1;
      cc = ~c;
      repeat (n - 3) begin @(posedge clock); #1; end
   endtask

   task automatic exp_fd(input string t);
      push(W_F, 1'b0, 1'b0, {t, ".F"});
      push(W_D, 1'b0, 1'b0, {t, ".D"});
   endtask

   task automatic do_ldi();
      exp_fd("ldi");
      push(W_LDI1, 1'b0, 1'b0, "ldi.LDI1");
      push(W_LDI2, 1'b1, 1'b0, "ldi.LDI2");
      run_instr(16'b000_001_0001_01_0111, 4'h0, 4);
   endtask

   task automatic do_alu(input logic [15:0] ins, input logic [3:0] c, input string t);
      exp_fd(t);
      exp_op = ins[15:13];
      push(W_ALU1, 1'b0, 1'b0, {t, ".ALU1"});
      push(W_ALU2, 1'b1, 1'b0, {t, ".ALU2"});
      run_instr(ins, c, 4);
   endtask

`ifdef MIN_SEQ_BRANCH_EN
   task automatic do_br(input logic [1:0] cond, input logic taken, input string t);
      exp_fd(t);
      push(taken ? W_BR1 : W_BN1, 1'b0, 1'b0, {t, taken ? ".BR1" : ".BN1"});
      push(taken ? W_BR2 : W_BN2, 1'b1, 1'b0, {t, taken ? ".BR2" : ".BN2"});
      run_instr({14'b000_011_0000_00_00, cond}, 4'h0, 4);
   endtask
`endif

   initial begin
      checks = 0; errors = 0; exp_op = 3'b000;
      reset = 1'b1; ifd = 16'h0; cc = 4'h0;
      push(W_ZERO, 1'b0, 1'b0, "reset");
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b0;
      push(W_ZERO, 1'b0, 1'b0, "idle");
      @(posedge clock); #1;

      do_ldi();

      exp_fd("ldx");
      push(W_X1, 1'b0, 1'b0, "ldx.X1");
      push(W_X2, 1'b0, 1'b0, "ldx.X2");
      push(W_X3, 1'b0, 1'b0, "ldx.X3");
      push(W_LD4, 1'b0, 1'b0, "ldx.LD4");
      push(W_LD5, 1'b1, 1'b0, "ldx.LD5");
      run_instr(16'b000_001_0011_10_0111, 4'h0, 7);

      exp_fd("stx");
      push(W_X1, 1'b0, 1'b0, "stx.X1");
      push(W_X2, 1'b0, 1'b0, "stx.X2");
      push(W_X3, 1'b0, 1'b0, "stx.X3");
      push(W_ST4, 1'b1, 1'b0, "stx.ST4");
      run_instr(16'b000_010_0011_10_0111, 4'h0, 6);

      // N=1 captured into ccshadow
      do_alu(16'b010_100_0010_00_0011, 4'b0010, "sub");
`ifdef MIN_SEQ_BRANCH_EN
      do_br(2'b01, 1'b1, "brN1");
`endif
      // C=1, N=0 captured
      do_alu(16'b011_100_0001_00_0010, 4'b0100, "and");
`ifdef MIN_SEQ_BRANCH_EN
      do_br(2'b01, 1'b0, "brN0");
      do_br(2'b10, 1'b1, "brC1");
      do_br(2'b11, 1'b0, "brNever");
      do_br(2'b00, 1'b1, "brAlways");
`endif

      exp_fd("ill");
      repeat (4) push(W_ZERO, 1'b0, 1'b1, "ill.HALT");
`ifdef MIN_SEQ_BRANCH_EN
      run_instr(16'b111_111_0000_00_0000, 4'h0, 6);
`else
      run_instr(16'b000_011_0000_00_0001, 4'h0, 6);
`endif

      reset = 1'b1;
      exp_op = 3'b000;
      push(W_ZERO, 1'b0, 1'b0, "rst2");
      @(posedge clock); #1;
      reset = 1'b0;
      push(W_ZERO, 1'b0, 1'b0, "idle2");
      @(posedge clock); #1;
      do_ldi();

      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clock);
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d entries left, want 0", q.size());
      end
      @(posedge clock); #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
